// File: rtl/two_way_bit_mux_pkg.sv
// Shared definitions for the two_way_bit_mux leaf select cell.
// Select encodings, the default counter width and the bit-select helper.
package two_way_bit_mux_pkg;

    localparam logic SEL_IN1   = 1'b0;
    localparam logic SEL_IN2   = 1'b1;
    localparam int   DEF_CNT_W = 8;

    // 2:1 bit select. The ternary keeps plain X propagation: an unknown select
    // resolves only when both data inputs agree.
    function automatic logic mux_bit(input logic in1, input logic in2, input logic sel);
        return (sel == SEL_IN2) ? in2 : in1;
    endfunction

endpackage

// File: rtl/two_way_bit_mux_cell.sv
// Combinational 2:1 single-bit select cell: out = select ? in2 : in1.
// No state and no clock. It stays valid while the registers are held in reset.
module two_way_bit_mux_cell
    import two_way_bit_mux_pkg::*;
(
    input  logic in1,
    input  logic in2,
    input  logic select,
    output logic out
);

    // Zero-latency select of the two data inputs.
    assign out = mux_bit(in1, in2, select);

endmodule

// File: rtl/two_way_bit_mux.sv
// two_way_bit_mux: a 2:1 bit select with three additions:
//   - a registered copy of the selected bit (out_q)
//   - a one-cycle pulse when the sampled select changes (sel_changed)
//   - an optional saturating count of those pulses (switch_count)
// The counter is built only when TWO_WAY_BIT_MUX_SWITCH_COUNT_EN is defined.
// Otherwise switch_count is tied to zero, and the port remains present.
module two_way_bit_mux
    import two_way_bit_mux_pkg::*;
#(
    parameter int   CNT_W     = DEF_CNT_W,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in1,
    input  logic             in2,
    input  logic             select,
    output logic             out,
    output logic             out_q,
    output logic             sel_changed,
    output logic [CNT_W-1:0] switch_count
);

    logic sel_q;

    two_way_bit_mux_cell u_cell (
        .in1    (in1),
        .in2    (in2),
        .select (select),
        .out    (out)
    );

    // Registered copy of the combinational output, one cycle behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= RESET_VAL;
        else        out_q <= out;
    end

    // Select edge detect. sel_q resets to SEL_IN1, so leaving reset with
    // select=1 produces a pulse on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= SEL_IN1;
            sel_changed <= 1'b0;
        end else begin
            sel_q       <= select;
            sel_changed <= (select != sel_q);
        end
    end

`ifdef TWO_WAY_BIT_MUX_SWITCH_COUNT_EN
    // Saturating count of sel_changed pulses. It holds at all-ones and does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            switch_count <= '0;
        else if (sel_changed && (switch_count != {CNT_W{1'b1}}))
            switch_count <= switch_count + 1'b1;
    end
`else
    assign switch_count = '0;
`endif

endmodule

// File: tb/tb_two_way_bit_mux.sv
// Directed bench for two_way_bit_mux with CNT_W=2.
// It covers the truth table, async reset, select toggling, counter saturation
// and the first edge after reset with select=1.
module tb_two_way_bit_mux;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in1, in2, select;
    logic          out, out_q, sel_changed;
    logic [CW-1:0] switch_count;

    int vectors = 0;
    int miscompares = 0;

    two_way_bit_mux #(.CNT_W(CW), .RESET_VAL(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in1          (in1),
        .in2          (in2),
        .select       (select),
        .out          (out),
        .out_q        (out_q),
        .sel_changed  (sel_changed),
        .switch_count (switch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected switch_count for a given number of sel_changed pulses.
    function automatic logic [31:0] exp_cnt(input int pulses);
`ifdef TWO_WAY_BIT_MUX_SWITCH_COUNT_EN
        return (pulses > 3) ? 32'd3 : 32'(pulses);
`else
        return 32'd0;
`endif
    endfunction

    // Hand-written truth table, indexed by {in1,in2,sel}.
    logic [7:0] tt = 8'b1101_1000;  // bit i = out for index i

    logic exp_o;
    int   pulses;

    initial begin
        rst_n = 1'b0; in1 = 1'b0; in2 = 1'b0; select = 1'b0;
        #2;
        chk("rst_out_q", 32'(out_q), 32'd0);
        chk("rst_sel_changed", 32'(sel_changed), 32'd0);
        chk("rst_count", 32'(switch_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Exhaustive truth table. Each step is held for 10 cycles (100 ns).
        for (int v = 0; v < 8; v++) begin
            {in1, in2, select} = 3'(v);
            exp_o = tt[v];
            #1;
            chk($sformatf("tt_out_%0d", v), 32'(out), 32'(exp_o));
            for (int c = 0; c < 10; c++) begin
                tick();
                chk($sformatf("tt_out_q_%0d", v), 32'(out_q), 32'(exp_o));
            end
        end

        // Mid-cycle async reset while out_q=1.
        in1 = 1'b1; in2 = 1'b0; select = 1'b0;
        tick();
        chk("pre_rst_out_q", 32'(out_q), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_q", 32'(out_q), 32'd0);
        chk("async_sel_changed", 32'(sel_changed), 32'd0);
        chk("async_count", 32'(switch_count), 32'd0);
        select = 1'b1;
        #1;
        chk("rst_out_track0", 32'(out), 32'd0);
        in2 = 1'b1;
        #1;
        chk("rst_out_track1", 32'(out), 32'd1);
        tick();
        chk("rst_hold_out_q", 32'(out_q), 32'd0);

        // Release reset with select=1. This gives one pulse on the first edge.
        in1 = 1'b1; in2 = 1'b0; select = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_pulse", 32'(sel_changed), 32'd1);
        tick();
        chk("post_rst_no_pulse", 32'(sel_changed), 32'd0);
        chk("post_rst_count", 32'(switch_count), exp_cnt(1));

        // Reset again with select=0, then toggle select every 3 cycles.
        select = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_count", 32'(switch_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_sel_changed", 32'(sel_changed), 32'd0);
        pulses = 0;
        for (int t = 0; t < 5; t++) begin
            select = ~select;
            #1;
            chk($sformatf("tog_out_%0d", t), 32'(out), select ? 32'd0 : 32'd1);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("tog_pulse_%0d_%0d", t, c), 32'(sel_changed), (c == 0) ? 32'd1 : 32'd0);
                if (c == 0) pulses++;
                chk($sformatf("tog_count_%0d_%0d", t, c), 32'(switch_count),
                    (c == 0) ? exp_cnt(pulses - 1) : exp_cnt(pulses));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
